// File: rtl/flit_credit_tx.sv
// rtl/flit_credit_tx.sv - credit-based flit link transmitter with packet-boundary stop
// Mirrors downstream queue occupancy as credits and only halts between packets.
module flit_credit_tx #(
  parameter int FLIT_W = 132,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              src_not_empty,
  input  logic [FLIT_W-1:0] src_data,
  output logic              src_deq_en,
  output logic              link_enq_en,
  output logic [FLIT_W-1:0] link_enq_data,
  input  logic              credit_ret,
  input  logic              stop_req,
  output logic              stopped,
  output logic [CNT_W-1:0]  credits,
  output logic              err_proto,
  output logic              err_credit
);

  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PKT     = 2'd1,
    STOPPED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  credits_q, credits_d;
  logic              send;
  logic              head_bit, tail_bit;
  logic              proto_hit;
  logic              credit_hit;

  assign head_bit   = src_data[FLIT_W-1];
  assign tail_bit   = src_data[FLIT_W-2];
  assign send       = src_not_empty && (credits_q != '0) && (state_q != STOPPED);
  assign src_deq_en = send;
  assign stopped    = (state_q == STOPPED);
  assign credits    = credits_q;

  // A send always wins over stop_req; stopping happens only outside a packet.
  always_comb begin
    state_d   = state_q;
    proto_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          if (!head_bit) begin
            proto_hit = 1'b1;
          end else if (!tail_bit) begin
            state_d = PKT;
          end
        end else if (stop_req) begin
          state_d = STOPPED;
        end
      end
      PKT: begin
        if (send) begin
          if (head_bit) begin
            proto_hit = 1'b1;
          end
          if (tail_bit) begin
            state_d = stop_req ? STOPPED : IDLE;
          end
        end
      end
      STOPPED: begin
        if (!stop_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit return saturates at DEPTH; a return with no room is flagged instead.
  always_comb begin
    credits_d  = credits_q;
    credit_hit = 1'b0;
    case ({send, credit_ret})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CREDIT_MAX) begin
          credit_hit = 1'b1;
        end else begin
          credits_d = credits_q + 1'b1;
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      credits_q     <= CREDIT_MAX;
      link_enq_en   <= 1'b0;
      link_enq_data <= '0;
      err_proto     <= 1'b0;
      err_credit    <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      link_enq_en <= send;
      if (send) begin
        link_enq_data <= src_data;
      end
      if (proto_hit) begin
        err_proto <= 1'b1;
      end
      if (credit_hit) begin
        err_credit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flit_credit_tx.sv
// tb/tb_flit_credit_tx.sv - randomized and directed bench for flit_credit_tx
// Compares every cycle against a packet-level model of the link transmitter.
module tb_flit_credit_tx;

  localparam int FLIT_W = 132;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              src_not_empty = 1'b0;
  logic [FLIT_W-1:0] src_data = '0;
  logic              src_deq_en;
  logic              link_enq_en;
  logic [FLIT_W-1:0] link_enq_data;
  logic              credit_ret = 1'b0;
  logic              stop_req = 1'b0;
  logic              stopped;
  logic [CNT_W-1:0]  credits;
  logic              err_proto;
  logic              err_credit;

  flit_credit_tx #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .src_not_empty(src_not_empty), .src_data(src_data), .src_deq_en(src_deq_en),
    .link_enq_en(link_enq_en), .link_enq_data(link_enq_data),
    .credit_ret(credit_ret), .stop_req(stop_req), .stopped(stopped),
    .credits(credits), .err_proto(err_proto), .err_credit(err_credit)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  // Model: free downstream slots, whether a packet is open, whether the link is halted.
  int                m_credits;
  bit                m_open, m_halted, m_enq, m_errp, m_errc, m_sent;
  logic [FLIT_W-1:0] m_data;
  bit                deq_seen;

  task automatic check(input string name, input logic [FLIT_W-1:0] act,
                       input logic [FLIT_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_credits = DEPTH; m_open = 0; m_halted = 0; m_enq = 0;
    m_errp = 0; m_errc = 0; m_data = '0; m_sent = 0;
  endtask

  task automatic check_regs();
    check("link_enq_en", FLIT_W'(link_enq_en), FLIT_W'(m_enq));
    check("link_enq_data", link_enq_data, m_data);
    check("credits", FLIT_W'(credits), FLIT_W'(m_credits));
    check("stopped", FLIT_W'(stopped), FLIT_W'(m_halted));
    check("err_proto", FLIT_W'(err_proto), FLIT_W'(m_errp));
    check("err_credit", FLIT_W'(err_credit), FLIT_W'(m_errc));
  endtask

  task automatic cycle(input bit ne, input logic [FLIT_W-1:0] d, input bit ret, input bit stop);
    bit snd, hd, tl;
    @(negedge CLK);
    check_regs();
    src_not_empty = ne; src_data = d; credit_ret = ret; stop_req = stop;
    #1;
    snd = ne && (m_credits > 0) && !m_halted;
    check("src_deq_en", FLIT_W'(src_deq_en), FLIT_W'(snd));
    deq_seen = src_deq_en;
    hd = d[FLIT_W-1]; tl = d[FLIT_W-2];
    if (ret && !snd && m_credits == DEPTH) m_errc = 1;
    m_credits = m_credits - int'(snd) + int'(ret);
    if (m_credits > DEPTH) m_credits = DEPTH;
    m_enq = snd;
    if (snd) m_data = d;
    if (m_halted) begin
      if (!stop) m_halted = 0;
    end else if (snd) begin
      if (m_open == hd) m_errp = 1;
      if (m_open) begin
        if (tl) begin m_open = 0; m_halted = stop; end
      end else begin
        m_open = hd && !tl;
      end
    end else if (!m_open && stop) begin
      m_halted = 1;
    end
    m_sent = snd;
    @(posedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 0; src_not_empty = 0; credit_ret = 0; stop_req = 0;
    @(posedge CLK);
    #1;
    RST_N = 1;
    model_reset();
    check("rst_credits", FLIT_W'(credits), FLIT_W'(DEPTH));
    check("rst_enq_en", FLIT_W'(link_enq_en), '0);
    check("rst_stopped", FLIT_W'(stopped), '0);
    check("rst_errs", FLIT_W'({err_proto, err_credit}), '0);
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] ht, input int pl);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_W-1:FLIT_W-2] = ht;
    f[31:0] = pl;
    return f;
  endfunction

  // Random packet source: well-formed packets of 1..4 flits, with an occasional flipped head bit.
  int                g_len = 0, g_pos = 0;
  logic [FLIT_W-1:0] cur_flit;

  task automatic new_flit();
    if (g_pos >= g_len) begin
      g_len = $urandom_range(1, 4);
      g_pos = 0;
    end
    cur_flit = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    cur_flit[FLIT_W-1] = (g_pos == 0);
    cur_flit[FLIT_W-2] = (g_pos == g_len - 1);
    if ($urandom_range(0, 39) == 0) cur_flit[FLIT_W-1] = ~cur_flit[FLIT_W-1];
    g_pos++;
  endtask

  int cnt;
  int occ;
  bit rnd_stop, rnd_ret;

  initial begin
    model_reset();
    do_reset();

    // Eight single-flit packets drain all credits; the ninth is held.
    for (int i = 0; i < 8; i++) cycle(1, mk(2'b11, i), 0, 0);
    cycle(1, mk(2'b11, 8), 0, 0);
    check("t1_ninth_held", FLIT_W'(deq_seen), '0);
    #1;
    check("t1_credits_zero", FLIT_W'(credits), '0);

    // Credit returned in cycle N allows a send in N+1, enq in N+2.
    cycle(1, mk(2'b11, 8), 1, 0);
    check("t2_no_send_N", FLIT_W'(deq_seen), '0);
    cycle(1, mk(2'b11, 8), 0, 0);
    check("t2_send_N1", FLIT_W'(deq_seen), 1);
    #1;
    check("t2_enq_N2", FLIT_W'(link_enq_en), 1);
    check("t2_enq_data", link_enq_data, mk(2'b11, 8));
    check("t2_credits", FLIT_W'(credits), '0);

    // Send plus return in the same cycle leaves credits at 5 while streaming.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, mk(2'b11, i), 0, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, mk(2'b11, 16 + i), 1, 0);
      cnt += int'(deq_seen);
    end
    check("t3_stream_count", FLIT_W'(cnt), 6);
    #1;
    check("t3_credits_5", FLIT_W'(credits), 5);

    // stop_req mid-packet waits for the tail.
    do_reset();
    cycle(1, mk(2'b10, 1), 0, 0);
    cycle(1, mk(2'b00, 2), 0, 1);
    cycle(1, mk(2'b00, 3), 0, 1);
    cycle(1, mk(2'b01, 4), 0, 1);
    check("t4_tail_sent", FLIT_W'(deq_seen), 1);
    #1;
    check("t4_stopped", FLIT_W'(stopped), 1);
    cycle(1, mk(2'b11, 5), 0, 1);
    check("t4_halt_hold", FLIT_W'(deq_seen), '0);
    cycle(1, mk(2'b11, 5), 0, 0);
    check("t4_release_cycle", FLIT_W'(deq_seen), '0);
    cycle(1, mk(2'b11, 5), 0, 0);
    check("t4_resume", FLIT_W'(deq_seen), 1);
    #1;
    check("t4_credits", FLIT_W'(credits), 3);

    // Credit overflow and missing head bit.
    do_reset();
    cycle(0, '0, 1, 0);
    #1;
    check("t5_err_credit", FLIT_W'(err_credit), 1);
    check("t5_credits_8", FLIT_W'(credits), 8);
    cycle(1, mk(2'b00, 7), 0, 0);
    check("t5_bad_sent", FLIT_W'(deq_seen), 1);
    #1;
    check("t5_err_proto", FLIT_W'(err_proto), 1);

    // Reset in the middle of an open packet.
    cycle(1, mk(2'b10, 9), 0, 0);
    cycle(1, mk(2'b00, 10), 0, 0);
    do_reset();
    cycle(1, mk(2'b00, 11), 0, 0);
    #1;
    check("t6_idle_after_rst", FLIT_W'(err_proto), 1);

    // Random traffic against a downstream queue that drains at a random rate.
    do_reset();
    occ = 0; g_len = 0; g_pos = 0; rnd_stop = 0;
    new_flit();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) rnd_stop = ~rnd_stop;
      rnd_ret = (occ > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 3) != 0, cur_flit, rnd_ret, rnd_stop);
      if (rnd_ret && occ > 0) occ--;
      if (m_sent) begin
        occ++;
        new_flit();
      end
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        occ = 0;
      end
    end
    @(negedge CLK);
    check_regs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
